// File: rtl/portal_request_deframer_pkg.sv
// Shared definitions for the portal request deframer: FSM states,
// header field layout and the default payload depth.
package portal_request_deframer_pkg;

   localparam int DEFAULT_MAX_WORDS = 4;

   localparam int METHOD_LSB = 16;
   localparam int METHOD_W   = 16;
   localparam int LENGTH_LSB = 0;
   localparam int LENGTH_W   = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PAYLOAD = 2'd1,
      HOLD    = 2'd2,
      DRAIN   = 2'd3
   } stateT;

endpackage

// File: rtl/portal_request_deframer.sv
// Reassembles a portal write stream (header + payload words) into one
// message and holds it until the downstream consumer takes it.
module portal_request_deframer
   import portal_request_deframer_pkg::*;
#(
   parameter int MAX_WORDS = DEFAULT_MAX_WORDS
) (
   input  logic                    CLK,
   input  logic                    nRST,
   input  logic                    in_enq__ENA,
   input  logic [31:0]             in_enq_v,
   input  logic                    in_enq_last,
   output logic                    in_enq__RDY,
   output logic                    out_enq__ENA,
   output logic [15:0]             out_enq_method,
   output logic [32*MAX_WORDS-1:0] out_enq_payload,
   output logic [3:0]              out_enq_count,
   input  logic                    out_enq__RDY,
   output logic [7:0]              err_count
);

   localparam logic [LENGTH_W-1:0] MAX_LEN = LENGTH_W'(MAX_WORDS);

   stateT               state;
   stateT               nextState;
   logic                errPulse;
   logic [3:0]          idx;
   logic [METHOD_W-1:0] method;
   logic [LENGTH_W-1:0] length;
   logic [3:0]          count;
   logic [7:0]          errCount;
   logic [31:0]         payloadBuf [MAX_WORDS];

   logic [METHOD_W-1:0] hdrMethod;
   logic [LENGTH_W-1:0] hdrLength;
   logic [LENGTH_W-1:0] nextIdx;

   assign hdrMethod = in_enq_v[METHOD_LSB +: METHOD_W];
   assign hdrLength = in_enq_v[LENGTH_LSB +: LENGTH_W];
   assign nextIdx   = LENGTH_W'(idx) + LENGTH_W'(1);

   assign in_enq__RDY    = (state != HOLD);
   assign out_enq__ENA   = (state == HOLD) && out_enq__RDY;
   assign out_enq_method = method;
   assign out_enq_count  = count;
   assign err_count      = errCount;

   always_comb begin
      out_enq_payload = '0;
      for (int unsigned i = 0; i < MAX_WORDS; i++) begin
         out_enq_payload[32*i +: 32] = payloadBuf[i];
      end
   end

   always_comb begin
      nextState = state;
      errPulse  = 1'b0;
      case (state)
         IDLE: begin
            if (in_enq__ENA) begin
               if (hdrLength > MAX_LEN || (hdrLength == '0 && !in_enq_last)) begin
                  errPulse  = 1'b1;
                  nextState = in_enq_last ? IDLE : DRAIN;
               end else if (hdrLength == '0) begin
                  nextState = HOLD;
               end else if (in_enq_last) begin
                  errPulse  = 1'b1;
                  nextState = IDLE;
               end else begin
                  nextState = PAYLOAD;
               end
            end
         end
         PAYLOAD: begin
            if (in_enq__ENA) begin
               if (in_enq_last) begin
                  if (nextIdx == length) begin
                     nextState = HOLD;
                  end else begin
                     errPulse  = 1'b1;
                     nextState = IDLE;
                  end
               end else if (nextIdx == length) begin
                  // Length reached without last: the rest of the stream is surplus.
                  errPulse  = 1'b1;
                  nextState = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (in_enq__ENA && in_enq_last) begin
               nextState = IDLE;
            end
         end
         HOLD: begin
            if (out_enq__ENA) begin
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state    <= IDLE;
         idx      <= '0;
         method   <= '0;
         length   <= '0;
         count    <= '0;
         errCount <= '0;
         for (int unsigned i = 0; i < MAX_WORDS; i++) begin
            payloadBuf[i] <= '0;
         end
      end else begin
         state <= nextState;
         if (errPulse && errCount != '1) begin
            errCount <= errCount + 8'd1;
         end
         if (state == IDLE && in_enq__ENA) begin
            method <= hdrMethod;
            length <= hdrLength;
            idx    <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < MAX_WORDS; i++) begin
               payloadBuf[i] <= '0;
            end
         end else if (state == PAYLOAD && in_enq__ENA) begin
            // Match-based write keeps every store inside the buffer.
            for (int unsigned i = 0; i < MAX_WORDS; i++) begin
               if (idx == 4'(i)) begin
                  payloadBuf[i] <= in_enq_v;
               end
            end
            idx <= idx + 4'd1;
            if (nextState == HOLD) begin
               count <= nextIdx[3:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_portal_request_deframer.sv
// Scoreboard bench: message-level reference model feeds an expected queue,
// an independent monitor compares every held/delivered message.
module tb_portal_request_deframer;

   localparam int MW = 4;

   logic           CLK = 1'b0;
   logic           nRST = 1'b0;
   logic           in_enq__ENA = 1'b0;
   logic [31:0]    in_enq_v = '0;
   logic           in_enq_last = 1'b0;
   logic           in_enq__RDY;
   logic           out_enq__ENA;
   logic [15:0]    out_enq_method;
   logic [32*MW-1:0] out_enq_payload;
   logic [3:0]     out_enq_count;
   logic           out_enq__RDY = 1'b1;
   logic [7:0]     err_count;

   portal_request_deframer #(.MAX_WORDS(MW)) dut (
      .CLK             (CLK),
      .nRST            (nRST),
      .in_enq__ENA     (in_enq__ENA),
      .in_enq_v        (in_enq_v),
      .in_enq_last     (in_enq_last),
      .in_enq__RDY     (in_enq__RDY),
      .out_enq__ENA    (out_enq__ENA),
      .out_enq_method  (out_enq_method),
      .out_enq_payload (out_enq_payload),
      .out_enq_count   (out_enq_count),
      .out_enq__RDY    (out_enq__RDY),
      .err_count       (err_count)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [15:0]      m;
      logic [3:0]       c;
      logic [32*MW-1:0] p;
   } expT;

   expT         expQ[$];
   expT         monE;
   logic [31:0] pay[$];
   int          total = 0;
   int          bad = 0;
   int          errModel = 0;
   logic        rndRdy = 1'b0;
   logic        rdyVal = 1'b1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   always @(posedge CLK) begin
      #1;
      out_enq__RDY = rndRdy ? ($urandom_range(0, 3) != 0) : rdyVal;
   end

   always @(negedge CLK) begin
      if (nRST) begin
         if (out_enq__ENA) begin
            check("ena_needs_rdy", out_enq__RDY, 1);
            if (expQ.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_delivery actual=method %0h required=no delivery", out_enq_method);
            end else begin
               monE = expQ.pop_front();
               check("deliver_method", out_enq_method, monE.m);
               check("deliver_count", out_enq_count, monE.c);
               check("deliver_payload", out_enq_payload, monE.p);
            end
         end else if (!in_enq__RDY) begin
            if (expQ.size() == 0) begin
               total++;
               bad++;
               $display("FAIL hold_without_message actual=in_enq__RDY 0 required=1");
            end else begin
               check("hold_method", out_enq_method, expQ[0].m);
               check("hold_count", out_enq_count, expQ[0].c);
               check("hold_payload", out_enq_payload, expQ[0].p);
            end
         end
      end
   end

   task automatic sendWord(input logic [31:0] v, input logic last);
      int t = 0;
      while (!in_enq__RDY && t < 200) begin
         @(posedge CLK);
         #1;
         t++;
      end
      if (!in_enq__RDY) begin
         total++;
         bad++;
         $display("FAIL rdy_timeout actual=in_enq__RDY 0 required=1");
         $display("test done: total=%0d bad=%0d", total, bad);
         $fatal(1, "input stream stalled");
      end
      in_enq__ENA = 1'b1;
      in_enq_v    = v;
      in_enq_last = last;
      @(posedge CLK);
      #1;
      in_enq__ENA = 1'b0;
      in_enq_last = 1'b0;
   endtask

   // Message-level model: well formed iff declared length fits and matches
   // the number of words actually sent; every malformed message costs one error.
   task automatic sendMsg(input logic [15:0] m, input logic [15:0] l, input int n);
      logic [32*MW-1:0] p = '0;
      bit good = (l <= 16'(MW)) && (n == int'(l));
      sendWord({m, l}, n == 0);
      for (int i = 0; i < n; i++) sendWord(pay[i], i == n - 1);
      if (good) begin
         for (int i = 0; i < n; i++) p[32*i +: 32] = pay[i];
         expQ.push_back('{m, 4'(l), p});
      end else if (errModel < 255) begin
         errModel++;
      end
      @(negedge CLK);
      check("err_count", err_count, errModel[7:0]);
      if (good) check("deliverable_next_cycle", in_enq__RDY, 0);
   endtask

   initial begin
      repeat (2) @(posedge CLK);
      #1 nRST = 1'b1;
      @(negedge CLK);
      check("rst_in_rdy", in_enq__RDY, 1);
      check("rst_out_ena", out_enq__ENA, 0);
      check("rst_err", err_count, 0);
      check("rst_method", out_enq_method, 0);
      check("rst_count", out_enq_count, 0);
      check("rst_payload", out_enq_payload, 0);

      pay = '{32'hA, 32'hB};             sendMsg(16'h3, 16'd2, 2);
      pay.delete();                      sendMsg(16'h7, 16'd0, 0);
      pay = '{32'h1, 32'h2};             sendMsg(16'h1, 16'd3, 2);
      pay = '{32'h11, 32'h22};           sendMsg(16'h4, 16'd2, 2);
      pay.delete();
      for (int i = 0; i < 9; i++) pay.push_back(32'h100 + 32'(i));
      sendMsg(16'h2, 16'd9, 9);
      check("oversize_idle", in_enq__RDY, 1);
      pay = '{32'h5, 32'h6, 32'h7, 32'h8}; sendMsg(16'h9, 16'd4, 4);
      pay = '{32'h5, 32'h6, 32'h7, 32'h8, 32'h9}; sendMsg(16'hA, 16'd5, 5);
      pay = '{32'h5, 32'h6, 32'h7, 32'h8}; sendMsg(16'h6, 16'd2, 4);
      pay = '{32'h5, 32'h6};             sendMsg(16'h8, 16'd0, 2);
      pay = '{32'h5};                    sendMsg(16'hB, 16'd1, 0);

      // Backpressure: consumer refuses for five cycles.
      rdyVal = 1'b0;
      @(posedge CLK);
      #1;
      pay = '{32'hA, 32'hB};
      sendMsg(16'h3, 16'd2, 2);
      repeat (4) begin
         @(negedge CLK);
         check("bp_in_rdy_low", in_enq__RDY, 0);
         check("bp_no_delivery", out_enq__ENA, 0);
      end
      rdyVal = 1'b1;
      @(negedge CLK);
      check("bp_deliver", out_enq__ENA, 1);
      @(negedge CLK);
      check("bp_in_rdy_back", in_enq__RDY, 1);

      rndRdy = 1'b1;
      for (int k = 0; k < 150; k++) begin
         int l = $urandom_range(0, 6);
         int n = ($urandom_range(0, 9) < 7) ? l : $urandom_range(0, 6);
         pay.delete();
         for (int i = 0; i < n; i++) pay.push_back($urandom());
         sendMsg(16'($urandom()), 16'(l), n);
      end
      rndRdy = 1'b0;
      rdyVal = 1'b1;
      repeat (4) @(negedge CLK);
      check("queue_drained", expQ.size(), 0);

      for (int k = 0; k < 260; k++) sendMsg(16'h5, 16'd1, 0);
      check("err_saturated", err_count, 8'd255);

      sendWord(32'h0003_0002, 1'b0);
      sendWord(32'hA, 1'b0);
      nRST = 1'b0;
      @(posedge CLK);
      #1 nRST = 1'b1;
      errModel = 0;
      @(negedge CLK);
      check("midrst_in_rdy", in_enq__RDY, 1);
      check("midrst_out_ena", out_enq__ENA, 0);
      check("midrst_err", err_count, 0);
      check("midrst_count", out_enq_count, 0);
      pay = '{32'hC, 32'hD};
      sendMsg(16'hE, 16'd2, 2);
      repeat (3) @(negedge CLK);
      check("final_queue_empty", expQ.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
